enemy_tank_driver: RTL and testbench

Autonomous direction sequencer for one enemy tank. It produces the 4-bit `inputKeyPressed` vector that drives the tank-movement block, standing in for the player's keypad. A frame-paced state machine picks a pseudo-random direction and holds it for a number of frames. On collision it stops, pauses, and re-picks a direction other than the one that was blocked. One instance sits next to each enemy tank's movement block in the top level.

---
 rtl/tank_pkg.sv | 37 +++
 rtl/lfsr16.sv | 25 ++
 rtl/enemy_tank_driver.sv | 134 +++++++++++++
 tb/tb_enemy_tank_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank types: movement directions, keypad bit positions and the
// enemy-driver FSM states.
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int KEY_DOWN  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PICK    = 2'd1,
    DRIVE   = 2'd2,
    BLOCKED = 2'd3
  } drv_state_t;

  function automatic logic [3:0] dir_to_key(input dir_t d);
    logic [3:0] k;
    k = '0;
    case (d)
      DIR_DOWN:  k[KEY_DOWN]  = 1'b1;
      DIR_UP:    k[KEY_UP]    = 1'b1;
      DIR_LEFT:  k[KEY_LEFT]  = 1'b1;
      DIR_RIGHT: k[KEY_RIGHT] = 1'b1;
      default:   k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11, free-running outside reset.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_reg;
  logic        feedback;

  assign feedback = q_reg[15] ^ q_reg[13] ^ q_reg[12] ^ q_reg[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= (seed == 16'd0) ? 16'h0001 : seed;
    end else begin
      q_reg <= {q_reg[14:0], feedback};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/enemy_tank_driver.sv
// Frame-paced direction sequencer for one enemy tank: picks a pseudo-random
// direction, holds it for a number of frames, and backs off after a collision.
module enemy_tank_driver
  import tank_pkg::*;
#(
  parameter logic [15:0] SEED            = 16'hACE1,
  parameter int          MIN_HOLD_FRAMES = 16,
  parameter bit          RANDOM_HOLD     = 1'b1,
  parameter int          PAUSE_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       tank_alive,
  input  logic       collision,
  output logic [3:0] keyOut,
  output logic [1:0] dir,
  output logic       moving
);

  localparam logic [7:0] MIN_HOLD   = 8'(MIN_HOLD_FRAMES);
  localparam logic [7:0] PAUSE_LOAD = 8'(PAUSE_FRAMES);

  logic [15:0] lfsr_q;
  logic [7:0]  lfsr_hi_unused;
  drv_state_t  state_reg, state_next;
  dir_t        dir_reg, dir_next, cand_dir;
  dir_t        blocked_dir_reg, blocked_dir_next;
  logic [3:0]  key_reg, key_next;
  logic        moving_reg;
  logic        blocked_valid_reg, blocked_valid_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [7:0]  pause_cnt_reg, pause_cnt_next;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign lfsr_hi_unused = lfsr_q[15:8];
  assign cand_dir       = dir_t'(lfsr_q[1:0]);

  always_comb begin
    state_next         = state_reg;
    dir_next           = dir_reg;
    key_next           = key_reg;
    blocked_valid_next = blocked_valid_reg;
    blocked_dir_next   = blocked_dir_reg;
    hold_cnt_next      = hold_cnt_reg;
    pause_cnt_next     = pause_cnt_reg;

    // Losing enable or the tank overrides every other transition.
    if (!enable || !tank_alive) begin
      state_next         = IDLE;
      key_next           = '0;
      blocked_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          key_next   = '0;
          state_next = PICK;
        end
        PICK: begin
          dir_next = (blocked_valid_reg && (cand_dir == blocked_dir_reg))
                   ? dir_t'(lfsr_q[1:0] + 2'd1) : cand_dir;
          hold_cnt_next      = MIN_HOLD + (RANDOM_HOLD ? {2'b00, lfsr_q[7:2]} : 8'd0);
          blocked_valid_next = 1'b0;
          key_next           = dir_to_key(dir_next);
          state_next         = DRIVE;
        end
        DRIVE: begin
          if (collision) begin
            state_next         = BLOCKED;
            blocked_dir_next   = dir_reg;
            blocked_valid_next = 1'b1;
            key_next           = '0;
            pause_cnt_next     = PAUSE_LOAD;
          end else if (startOfFrame) begin
            if (hold_cnt_reg <= 8'd1) begin
              key_next   = '0;
              state_next = PICK;
            end else begin
              hold_cnt_next = hold_cnt_reg - 8'd1;
            end
          end
        end
        BLOCKED: begin
          key_next = '0;
          if (startOfFrame) begin
            if (pause_cnt_reg <= 8'd1) begin
              state_next = PICK;
            end else begin
              pause_cnt_next = pause_cnt_reg - 8'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          key_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      dir_reg           <= DIR_DOWN;
      key_reg           <= '0;
      moving_reg        <= 1'b0;
      blocked_valid_reg <= 1'b0;
      blocked_dir_reg   <= DIR_DOWN;
      hold_cnt_reg      <= '0;
      pause_cnt_reg     <= '0;
    end else begin
      state_reg         <= state_next;
      dir_reg           <= dir_next;
      key_reg           <= key_next;
      moving_reg        <= |key_next;
      blocked_valid_reg <= blocked_valid_next;
      blocked_dir_reg   <= blocked_dir_next;
      hold_cnt_reg      <= hold_cnt_next;
      pause_cnt_reg     <= pause_cnt_next;
    end
  end

  assign keyOut = key_reg;
  assign dir    = dir_reg;
  assign moving = moving_reg;

endmodule

// File: tb/tb_enemy_tank_driver.sv
// Bench for enemy_tank_driver: two instances (fixed 3-frame hold, and random
// hold with a zero seed) checked cycle by cycle against a reference model.
module tb_enemy_tank_driver;
  import tank_pkg::*;

  logic clk;
  logic rst, en, alive, col, sof;
  logic [3:0] key_a, key_b;
  logic [1:0] dir_a, dir_b;
  logic       mov_a, mov_b;

  int errors = 0;
  int checks = 0;

  enemy_tank_driver #(.SEED(16'hACE1), .MIN_HOLD_FRAMES(3), .RANDOM_HOLD(1'b0), .PAUSE_FRAMES(8)) dut_a (
    .clk(clk), .reset(rst), .startOfFrame(sof), .enable(en), .tank_alive(alive),
    .collision(col), .keyOut(key_a), .dir(dir_a), .moving(mov_a)
  );

  enemy_tank_driver #(.SEED(16'h0000), .MIN_HOLD_FRAMES(16), .RANDOM_HOLD(1'b1), .PAUSE_FRAMES(8)) dut_b (
    .clk(clk), .reset(rst), .startOfFrame(sof), .enable(en), .tank_alive(alive),
    .collision(col), .keyOut(key_b), .dir(dir_b), .moving(mov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] lfsr;
    drv_state_t  st;
    logic [1:0]  dir;
    logic [3:0]  key;
    logic        bv;
    logic [1:0]  bdir;
    logic [7:0]  hold;
    logic [7:0]  pause;
  } mdl_t;

  typedef struct {
    logic [4:0] in;   // {reset, enable, alive, collision, startOfFrame}
    drv_state_t st;
    logic       mov;
    logic [7:0] hold;
  } vec_t;

  mdl_t ma, mb;
  mdl_t qa[$];
  mdl_t qb[$];
  vec_t tbl[20];

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic r, input logic e, input logic a,
                                 input logic c, input logic s, input logic [7:0] minh,
                                 input logic rh, input logic [7:0] pf, input logic [15:0] seed);
    mdl_t n;
    logic [1:0] cd;
    n = m;
    if (r) begin
      n = '0;
      n.st = IDLE;
      n.lfsr = (seed == 16'd0) ? 16'h0001 : seed;
      return n;
    end
    n.lfsr = lfsr_adv(m.lfsr);
    if (!(e && a)) begin
      n.st = IDLE;
      n.key = 4'd0;
      n.bv = 1'b0;
      return n;
    end
    case (m.st)
      IDLE: n.st = PICK;
      PICK: begin
        cd = m.lfsr[1:0];
        if (m.bv && cd == m.bdir) cd = cd + 2'd1;
        n.dir  = cd;
        n.key  = 4'b0001 << cd;
        n.hold = minh + (rh ? {2'b00, m.lfsr[7:2]} : 8'd0);
        n.bv   = 1'b0;
        n.st   = DRIVE;
      end
      DRIVE: begin
        if (c) begin
          n.st = BLOCKED; n.bdir = m.dir; n.bv = 1'b1; n.key = 4'd0; n.pause = pf;
        end else if (s) begin
          if (m.hold == 8'd1) begin n.key = 4'd0; n.st = PICK; end
          else n.hold = m.hold - 8'd1;
        end
      end
      default: begin
        if (s) begin
          if (m.pause == 8'd1) n.st = PICK;
          else n.pause = m.pause - 8'd1;
        end
      end
    endcase
    return n;
  endfunction

  function automatic vec_t mk(input logic [4:0] in, input drv_state_t st, input logic mov,
                              input logic [7:0] hold);
    vec_t v;
    v.in = in; v.st = st; v.mov = mov; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the model's expectation, compare after the edge.
  task automatic tick(input logic r, input logic e, input logic a, input logic c, input logic s);
    mdl_t xa, xb;
    rst = r; en = e; alive = a; col = c; sof = s;
    ma = mstep(ma, r, e, a, c, s, 8'd3, 1'b0, 8'd8, 16'hACE1);
    mb = mstep(mb, r, e, a, c, s, 8'd16, 1'b1, 8'd8, 16'h0000);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    xa = qa.pop_front();
    xb = qb.pop_front();
    chk("key_a", 16'(key_a), 16'(xa.key));
    chk("dir_a", 16'(dir_a), 16'(xa.dir));
    chk("moving_a", 16'(mov_a), 16'(|xa.key));
    chk("state_a", 16'(dut_a.state_reg), 16'(xa.st));
    chk("hold_a", 16'(dut_a.hold_cnt_reg), 16'(xa.hold));
    chk("pause_a", 16'(dut_a.pause_cnt_reg), 16'(xa.pause));
    chk("key_b", 16'(key_b), 16'(xb.key));
    chk("dir_b", 16'(dir_b), 16'(xb.dir));
    chk("moving_b", 16'(mov_b), 16'(|xb.key));
    chk("state_b", 16'(dut_b.state_reg), 16'(xb.st));
    chk("hold_b", 16'(dut_b.hold_cnt_reg), 16'(xb.hold));
    chk("pause_b", 16'(dut_b.pause_cnt_reg), 16'(xb.pause));
    chk("onehot_a", 16'($onehot0(key_a)), 16'd1);
    chk("onehot_b", 16'($onehot0(key_b)), 16'd1);
    chk("moving_eq_b", 16'(mov_b), 16'(|key_b));
    $display("cyc in=%b%b%b%b%b a:key=%b st=%0d b:key=%b st=%0d", r, e, a, c, s,
             key_a, dut_a.state_reg, key_b, dut_b.state_reg);
  endtask

  // Idle-wait (with the given enable) until the next PICK cycle will see lfsr[1:0] == 2.
  task automatic align_left(input string name, input logic e);
    logic [15:0] nx;
    int guard;
    guard = 0;
    nx = lfsr_adv(ma.lfsr);
    while (nx[1:0] != 2'd2 && guard < 64) begin
      tick(1'b0, e, 1'b1, 1'b0, 1'b0);
      guard++;
      nx = lfsr_adv(ma.lfsr);
    end
    chk(name, 16'(nx[1:0]), 16'd2);
  endtask

  initial begin
    int frames, cyc;
    logic s, c, e, a, in_range;
    drv_state_t prev_b;
    ma = '0; mb = '0;
    rst = 1'b1; en = 1'b0; alive = 1'b1; col = 1'b0; sof = 1'b0;

    tbl[0]  = mk(5'b10100, IDLE,    1'b0, 8'd0);
    tbl[1]  = mk(5'b10100, IDLE,    1'b0, 8'd0);
    tbl[2]  = mk(5'b10100, IDLE,    1'b0, 8'd0);
    tbl[3]  = mk(5'b00101, IDLE,    1'b0, 8'd0);
    tbl[4]  = mk(5'b01100, PICK,    1'b0, 8'd0);
    tbl[5]  = mk(5'b01100, DRIVE,   1'b1, 8'd3);
    tbl[6]  = mk(5'b01101, DRIVE,   1'b1, 8'd2);
    tbl[7]  = mk(5'b01100, DRIVE,   1'b1, 8'd2);
    tbl[8]  = mk(5'b01101, DRIVE,   1'b1, 8'd1);
    tbl[9]  = mk(5'b01101, PICK,    1'b0, 8'd1);
    tbl[10] = mk(5'b01100, DRIVE,   1'b1, 8'd3);
    tbl[11] = mk(5'b01111, BLOCKED, 1'b0, 8'd3);
    tbl[12] = mk(5'b01101, BLOCKED, 1'b0, 8'd3);
    tbl[13] = mk(5'b01000, IDLE,    1'b0, 8'd3);
    tbl[14] = mk(5'b01100, PICK,    1'b0, 8'd3);
    tbl[15] = mk(5'b01100, DRIVE,   1'b1, 8'd3);
    tbl[16] = mk(5'b01000, IDLE,    1'b0, 8'd3);
    tbl[17] = mk(5'b01100, PICK,    1'b0, 8'd3);
    tbl[18] = mk(5'b01100, DRIVE,   1'b1, 8'd3);
    tbl[19] = mk(5'b11100, IDLE,    1'b0, 8'd0);

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      chk($sformatf("vec%0d_state", i), 16'(dut_a.state_reg), 16'(tbl[i].st));
      chk($sformatf("vec%0d_moving", i), 16'(mov_a), 16'(tbl[i].mov));
      chk($sformatf("vec%0d_hold", i), 16'(dut_a.hold_cnt_reg), 16'(tbl[i].hold));
    end

    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("disabled_key", 16'(key_a), 16'd0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Steer into a LEFT drive, collide, then re-pick while the LFSR still proposes LEFT.
    align_left("align_first_pick", 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dir_left", 16'(dir_a), 16'd2);
    chk("key_left", 16'(key_a), 16'h4);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("collision_stop", 16'(key_a), 16'd0);
    for (int p = 0; p < 7; p++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("pause_key", 16'(key_a), 16'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("pause_still_blocked", 16'(dut_a.state_reg), 16'(BLOCKED));
    align_left("align_repick", 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("repick_gap", 16'(key_a), 16'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dir_skip_blocked", 16'(dir_a), 16'd3);
    chk("key_skip_blocked", 16'(key_a), 16'h8);

    frames = 0;
    cyc = 0;
    while (frames < 2000 && cyc < 20000) begin
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 499) != 0);
      a = ($urandom_range(0, 499) != 0);
      prev_b = mb.st;
      tick(1'b0, e, a, c, s);
      if (prev_b == PICK && e && a) begin
        in_range = (dut_b.hold_cnt_reg >= 8'd16) && (dut_b.hold_cnt_reg <= 8'd79);
        chk("hold_range_b", 16'(in_range), 16'd1);
      end
      if (s) frames++;
      cyc++;
    end
    chk("random_frames_done", 16'(frames >= 2000), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
